// File: rtl/dram_burst_sequencer_pkg.sv
// Shared types and defaults for the DRAM burst sequencer.
//   burst_state_t : sequencer FSM states
//   beat_t        : beat index, drives the 3-bit column select
//   is_burst()    : true in the two data-window states
package dram_burst_sequencer_pkg;

   localparam int BURST_LEN_DEF = 8;
   localparam int TIMEOUT_DEF   = 64;

   typedef logic [2:0] beat_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_WAIT,
      ST_WR_BURST,
      ST_RD_WAIT,
      ST_RD_BURST,
      ST_RSP
   } burst_state_t;

   function automatic logic is_burst(input burst_state_t s);
      return (s == ST_WR_BURST) || (s == ST_RD_BURST);
   endfunction

endpackage

// File: rtl/dram_burst_sequencer_beat_counter.sv
// Burst beat counter: beat index plus inter-beat timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force beat and timeout counter to zero
//   run      : inside a data window (timeout counter advances)
//   step     : data-transfer stage moved one beat this cycle
//   beat     : current beat index
//   last     : beat is the final beat of the burst
//   expired  : no beat for too long; the burst must abort
module dram_burst_sequencer_beat_counter
   import dram_burst_sequencer_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  clear,
   input  logic  run,
   input  logic  step,
   output beat_t beat,
   output logic  last,
   output logic  expired
);

   localparam int TMO_W = $clog2(TIMEOUT);

   logic [TMO_W-1:0] tmo;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         beat <= '0;
         tmo  <= '0;
      end else if (run) begin
         if (step) begin
            tmo  <= '0;
            beat <= last ? '0 : beat + beat_t'(1);
         end else begin
            tmo  <= tmo + TMO_W'(1);
         end
      end
   end

   assign last = (beat == beat_t'(BURST_LEN - 1));

   // Flagged one cycle early so the abort pulse lands in the cycle the
   // counter would reach TIMEOUT-1. A beat in the same cycle always wins.
   assign expired = run && !step && (tmo == TMO_W'(TIMEOUT - 2));

endmodule

// File: rtl/dram_burst_sequencer.sv
// DRAM burst sequencer: accepts a write line or read request from the
// controller front end and steps the data-transfer stage beat by beat
// inside the data window opened by the command scheduler.
//   CLK, RST            : clock, synchronous active-high reset
//   req_valid/ready     : front-end request handshake (ready only in IDLE)
//   req_write, req_wdata: direction and write line (beat i at [i*WORD_W +: WORD_W])
//   wr_go, rd_go        : scheduler opens the write / read data window
//   burst_done/err      : 1-cycle pulses, burst finished / aborted on timeout
//   rsp_valid/ready     : read line handshake, rsp_rdata same packing as req_wdata
//   wr_en, rd_en, clear : controls to the data-transfer stage
//   COL_choice, memstore: current beat index and write beat
//   memload, edge_flag  : read beat and per-beat advance from the data-transfer stage
module dram_burst_sequencer
   import dram_burst_sequencer_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [BURST_LEN*WORD_W-1:0] req_wdata,
   input  logic                        wr_go,
   input  logic                        rd_go,
   output logic                        burst_done,
   output logic                        burst_err,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [BURST_LEN*WORD_W-1:0] rsp_rdata,
   output logic                        wr_en,
   output logic                        rd_en,
   output logic                        clear,
   output logic [2:0]                  COL_choice,
   output logic [WORD_W-1:0]           memstore,
   input  logic [WORD_W-1:0]           memload,
   input  logic                        edge_flag
);

   localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   burst_state_t                   state, state_next;
   logic [BURST_LEN-1:0][WORD_W-1:0] line;
   beat_t                          beat;
   logic [IDX_W-1:0]               idx;
   logic                           last, expired, step, in_burst, cnt_clear;

   assign idx       = beat[IDX_W-1:0];
   assign in_burst  = is_burst(state);
   assign step      = in_burst && edge_flag;
   // Counter sits at zero whenever the next cycle is not a data window,
   // so every burst starts from beat 0 with a fresh timeout.
   assign cnt_clear = !is_burst(state_next);

   dram_burst_sequencer_beat_counter #(
      .BURST_LEN (BURST_LEN),
      .TIMEOUT   (TIMEOUT)
   ) u_beat_counter (
      .clk     (CLK),
      .rst     (RST),
      .clear   (cnt_clear),
      .run     (in_burst),
      .step    (step),
      .beat    (beat),
      .last    (last),
      .expired (expired)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         burst_done <= 1'b0;
         burst_err  <= 1'b0;
         clear      <= 1'b0;
      end else begin
         burst_done <= step && last;
         burst_err  <= expired;
         clear      <= (step && last) || expired;
      end
   end

   // Line buffer holds data only; it survives reset and aborts untouched
   // apart from beats already written.
   always_ff @(posedge CLK) begin
      if (state == ST_IDLE && req_valid && req_write)
         line <= req_wdata;
      else if (state == ST_RD_BURST && edge_flag)
         line[idx] <= memload;
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      COL_choice = '0;
      memstore   = '0;
      rsp_valid  = 1'b0;
      rsp_rdata  = '0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = req_write ? ST_WR_WAIT : ST_RD_WAIT;
         end
         ST_WR_WAIT: if (wr_go) state_next = ST_WR_BURST;
         ST_RD_WAIT: if (rd_go) state_next = ST_RD_BURST;
         ST_WR_BURST: begin
            wr_en      = 1'b1;
            COL_choice = beat;
            memstore   = line[idx];
            if ((step && last) || expired) state_next = ST_IDLE;
         end
         ST_RD_BURST: begin
            rd_en      = 1'b1;
            COL_choice = beat;
            if (step && last)  state_next = ST_RSP;
            else if (expired)  state_next = ST_IDLE;
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            rsp_rdata = line;
            if (rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule
